// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and the pixel generators.
interface vga_timing_gen_if #(
    parameter int CW = 10
);
    logic          enable;
    logic          restart;
    logic          p_tick;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          video_on;
    logic          hsync;
    logic          vsync;
    logic          line_start;
    logic          frame_start;
    logic [7:0]    frame_count;

    // Timing generator side
    modport master (
        input  enable, restart,
        output p_tick, x, y, video_on, hsync, vsync,
               line_start, frame_start, frame_count
    );

    // Consumer / controller side
    modport slave (
        output enable, restart,
        input  p_tick, x, y, video_on, hsync, vsync,
               line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-clock divider,
// registered sync/blank decodes aligned to x/y, and frame counter.
module vga_timing_gen #(
    parameter int   H_DISPLAY = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_DISPLAY = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter int   CLK_DIV   = 2,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   CW        = 10
) (
    input  logic             clk_50MHz,
    input  logic             reset,
    vga_timing_gen_if.master vga
);
    localparam logic [CW-1:0] HMAX     = CW'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CW-1:0] VMAX     = CW'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_DISPLAY);
    localparam logic [CW-1:0] V_VIS    = CW'(V_DISPLAY);
    localparam logic [CW-1:0] HS_START = CW'(H_DISPLAY + H_FRONT);
    localparam logic [CW-1:0] HS_END   = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_START = CW'(V_DISPLAY + V_FRONT);
    localparam logic [CW-1:0] VS_END   = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic [CW-1:0] x_q, y_q;
    logic [CW-1:0] x_next, y_next;
    logic          video_on_q, hsync_q, vsync_q;
    logic          video_on_next, hsync_next, vsync_next;
    logic [7:0]    frame_count_q;
    logic          frame_wrap;
    logic          p_tick;

    // Pixel strobe; held low during reset so no tick is seen before release
    assign p_tick = vga.enable && !reset && (div_cnt == DIV_LAST);

    // Coordinates after the next tick, and the decodes that describe them;
    // registering these keeps sync/blank exactly aligned with x/y
    always_comb begin
        x_next     = x_q + 1'b1;
        y_next     = y_q;
        frame_wrap = 1'b0;
        if (x_q == HMAX) begin
            x_next = '0;
            if (y_q == VMAX) begin
                y_next     = '0;
                frame_wrap = 1'b1;
            end else begin
                y_next = y_q + 1'b1;
            end
        end
        video_on_next = (x_next < H_VIS) && (y_next < V_VIS);
        hsync_next    = ((x_next >= HS_START) && (x_next <= HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_next    = ((y_next >= VS_START) && (y_next <= VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    end

    // Divider, raster counters, registered decodes and frame counter
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            div_cnt       <= '0;
            x_q           <= '0;
            y_q           <= '0;
            video_on_q    <= 1'b1;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            frame_count_q <= '0;
        end else if (vga.restart) begin
            div_cnt    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            video_on_q <= 1'b1;
            hsync_q    <= ~HSYNC_POL;
            vsync_q    <= ~VSYNC_POL;
        end else if (vga.enable) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            if (p_tick) begin
                x_q        <= x_next;
                y_q        <= y_next;
                video_on_q <= video_on_next;
                hsync_q    <= hsync_next;
                vsync_q    <= vsync_next;
                if (frame_wrap) begin
                    frame_count_q <= frame_count_q + 8'd1;
                end
            end
        end
    end

    assign vga.p_tick      = p_tick;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.video_on    = video_on_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.line_start  = p_tick && (x_q == '0);
    assign vga.frame_start = p_tick && (x_q == '0) && (y_q == '0);
    assign vga.frame_count = frame_count_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: default geometry (CLK_DIV=2) and small geometry
// (CLK_DIV=1, positive hsync) against an arithmetic raster model.
module tb_vga_timing_gen;
    logic clk_50MHz = 1'b0;
    always #5 clk_50MHz = ~clk_50MHz;

    logic a_reset;
    logic b_reset;

    vga_timing_gen_if #(.CW(10)) va ();
    vga_timing_gen_if #(.CW(4))  vb ();

    vga_timing_gen #(.CLK_DIV(2)) u_a (
        .clk_50MHz (clk_50MHz),
        .reset     (a_reset),
        .vga       (va)
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CW(4)
    ) u_b (
        .clk_50MHz (clk_50MHz),
        .reset     (b_reset),
        .vga       (vb)
    );

    typedef struct packed {
        int hd; int hf; int hs; int hb;
        int vd; int vf; int vs; int vb;
        int div; int hp; int vp;
    } geom_t;

    localparam geom_t GA = '{hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33, div:2, hp:0, vp:0};
    localparam geom_t GB = '{hd:8, hf:2, hs:2, hb:2, vd:4, vf:1, vs:1, vb:1, div:1, hp:1, vp:0};

    typedef struct {
        int p_tick; int line_start; int frame_start;
        int video_on; int hsync; int vsync;
        int x; int y; int fc;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    // Model state: enabled clocks since last reset/restart, frame count at that point
    int a_en = 0, a_fcb = 0;
    int b_en = 0, b_fcb = 0;

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Raster position follows purely from the count of elapsed pixel ticks
    function automatic exp_t model(geom_t g, int en_clk, int fcb, logic en, logic rst);
        exp_t e;
        int   hp1, vp1, ticks;
        hp1          = g.hd + g.hf + g.hs + g.hb;
        vp1          = g.vd + g.vf + g.vs + g.vb;
        ticks        = en_clk / g.div;
        e.x          = ticks % hp1;
        e.y          = (ticks / hp1) % vp1;
        e.fc         = (fcb + ticks / (hp1 * vp1)) % 256;
        e.p_tick     = (en && !rst && (en_clk % g.div == g.div - 1)) ? 1 : 0;
        e.line_start = (e.p_tick == 1 && e.x == 0) ? 1 : 0;
        e.frame_start = (e.line_start == 1 && e.y == 0) ? 1 : 0;
        e.video_on   = (e.x < g.hd && e.y < g.vd) ? 1 : 0;
        e.hsync      = (e.x >= g.hd + g.hf && e.x < g.hd + g.hf + g.hs) ? g.hp : 1 - g.hp;
        e.vsync      = (e.y >= g.vd + g.vf && e.y < g.vd + g.vf + g.vs) ? g.vp : 1 - g.vp;
        return e;
    endfunction

    function automatic int model_fc(geom_t g, int en_clk, int fcb);
        exp_t e;
        e = model(g, en_clk, fcb, 1'b0, 1'b0);
        return e.fc;
    endfunction

    // Model advance on each active edge
    always @(posedge clk_50MHz) begin
        if (a_reset) begin
            a_en <= 0; a_fcb <= 0;
        end else if (va.restart) begin
            a_en <= 0; a_fcb <= model_fc(GA, a_en, a_fcb);
        end else if (va.enable) begin
            a_en <= a_en + 1;
        end
        if (b_reset) begin
            b_en <= 0; b_fcb <= 0;
        end else if (vb.restart) begin
            b_en <= 0; b_fcb <= model_fc(GB, b_en, b_fcb);
        end else if (vb.enable) begin
            b_en <= b_en + 1;
        end
    end

    // Every-cycle comparison of both DUTs against the model
    always @(negedge clk_50MHz) begin
        exp_t e;
        if (chk_on) begin
            e = model(GA, a_en, a_fcb, va.enable, a_reset);
            chk("A.p_tick", int'(va.p_tick), e.p_tick);
            chk("A.line_start", int'(va.line_start), e.line_start);
            chk("A.frame_start", int'(va.frame_start), e.frame_start);
            chk("A.video_on", int'(va.video_on), e.video_on);
            chk("A.hsync", int'(va.hsync), e.hsync);
            chk("A.vsync", int'(va.vsync), e.vsync);
            chk("A.x", int'(va.x), e.x);
            chk("A.y", int'(va.y), e.y);
            chk("A.frame_count", int'(va.frame_count), e.fc);
            e = model(GB, b_en, b_fcb, vb.enable, b_reset);
            chk("B.p_tick", int'(vb.p_tick), e.p_tick);
            chk("B.line_start", int'(vb.line_start), e.line_start);
            chk("B.frame_start", int'(vb.frame_start), e.frame_start);
            chk("B.video_on", int'(vb.video_on), e.video_on);
            chk("B.hsync", int'(vb.hsync), e.hsync);
            chk("B.vsync", int'(vb.vsync), e.vsync);
            chk("B.x", int'(vb.x), e.x);
            chk("B.y", int'(vb.y), e.y);
            chk("B.frame_count", int'(vb.frame_count), e.fc);
        end
    end

    task automatic run(int n);
        repeat (n) @(posedge clk_50MHz);
        @(negedge clk_50MHz);
    endtask

    task automatic wait_a_xy(int tx, int ty, int budget, string name);
        int k = 0;
        while (!(int'(va.x) == tx && int'(va.y) == ty) && k < budget) begin
            @(negedge clk_50MHz);
            k++;
        end
        chk(name, (k < budget) ? 1 : 0, 1);
    endtask

    typedef struct {
        logic rst; logic rs; logic en; int n;
        int x; int y; int von; int hs; int vs; int fc;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int von_cnt, von_bad, hs_cnt, hs_min, hs_max, ls_cnt, seq_bad, samples, k;
        int fs_cnt, fs_first, fs_last, pt_cnt, fc_hold;

        // Small geometry: HMAX=13, VMAX=6, hsync high x 10..11, vsync low y 5
        tbl[0]  = '{1'b1, 1'b0, 1'b1,  2,  0, 0, 1, 0, 1, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 10, 10, 0, 0, 1, 1, 0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1,  2, 12, 0, 0, 0, 1, 0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1,  2,  0, 1, 1, 0, 1, 0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 56,  0, 5, 0, 0, 0, 0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0,  5,  0, 5, 0, 0, 0, 0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 27, 13, 6, 0, 0, 1, 0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1,  1,  0, 0, 1, 0, 1, 1};
        tbl[8]  = '{1'b0, 1'b1, 1'b1,  1,  0, 0, 1, 0, 1, 1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1,  3,  3, 0, 1, 0, 1, 1};
        tbl[10] = '{1'b0, 1'b1, 1'b0,  1,  0, 0, 1, 0, 1, 1};
        tbl[11] = '{1'b1, 1'b1, 1'b1,  1,  0, 0, 1, 0, 1, 0};

        a_reset = 1'b1; va.enable = 1'b1; va.restart = 1'b0;
        b_reset = 1'b1; vb.enable = 1'b1; vb.restart = 1'b0;
        @(posedge clk_50MHz);
        #1 chk_on = 1'b1;

        for (int i = 0; i < 12; i++) begin
            #1;
            b_reset = tbl[i].rst; vb.restart = tbl[i].rs; vb.enable = tbl[i].en;
            run(tbl[i].n);
            chk($sformatf("tbl[%0d].x", i), int'(vb.x), tbl[i].x);
            chk($sformatf("tbl[%0d].y", i), int'(vb.y), tbl[i].y);
            chk($sformatf("tbl[%0d].video_on", i), int'(vb.video_on), tbl[i].von);
            chk($sformatf("tbl[%0d].hsync", i), int'(vb.hsync), tbl[i].hs);
            chk($sformatf("tbl[%0d].vsync", i), int'(vb.vsync), tbl[i].vs);
            chk($sformatf("tbl[%0d].frame_count", i), int'(vb.frame_count), tbl[i].fc);
        end

        // Small geometry: restart with both syncs active, then frame period
        #1; b_reset = 1'b0; vb.restart = 1'b0; vb.enable = 1'b1;
        run(80);
        chk("B.pre_restart.hsync", int'(vb.hsync), 1);
        chk("B.pre_restart.vsync", int'(vb.vsync), 0);
        #1; vb.restart = 1'b1;
        run(1);
        chk("B.restart.x", int'(vb.x), 0);
        chk("B.restart.y", int'(vb.y), 0);
        chk("B.restart.hsync", int'(vb.hsync), 0);
        chk("B.restart.vsync", int'(vb.vsync), 1);
        #1; vb.restart = 1'b0;
        fs_cnt = 0; fs_first = -1; fs_last = -1; pt_cnt = 0;
        for (int i = 0; i < 196; i++) begin
            @(negedge clk_50MHz);
            if (vb.p_tick) pt_cnt++;
            if (vb.frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = i;
                fs_last = i;
            end
        end
        chk("B.p_tick_constant", pt_cnt, 196);
        chk("B.frame_start_count", fs_cnt, 2);
        chk("B.frame_period", fs_last - fs_first, 98);

        // Default geometry: reset values, then tick cadence after release
        #1; vb.enable = 1'b0;
        chk("A.reset.x", int'(va.x), 0);
        chk("A.reset.video_on", int'(va.video_on), 1);
        chk("A.reset.hsync", int'(va.hsync), 1);
        chk("A.reset.vsync", int'(va.vsync), 1);
        chk("A.reset.p_tick", int'(va.p_tick), 0);
        chk("A.reset.frame_count", int'(va.frame_count), 0);
        a_reset = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk_50MHz);
            chk($sformatf("A.cadence[%0d].p_tick", i), int'(va.p_tick), i % 2);
            if (i == 2) chk("A.cadence.x_after_2", int'(va.x), 1);
        end

        // One full default line from a clean restart
        #1; va.restart = 1'b1;
        run(1);
        #1; va.restart = 1'b0;
        von_cnt = 0; von_bad = 0; hs_cnt = 0; hs_min = 9999; hs_max = -1;
        ls_cnt = 0; seq_bad = 0; samples = 0; k = 0;
        while (samples < 801 && k < 2000) begin
            @(negedge clk_50MHz);
            k++;
            if (va.p_tick) begin
                if (samples < 800) begin
                    if (int'(va.x) != samples || va.y != 0) seq_bad++;
                    if (va.video_on) begin
                        von_cnt++;
                        if (va.x >= 640) von_bad++;
                    end
                    if (!va.hsync) begin
                        hs_cnt++;
                        if (int'(va.x) < hs_min) hs_min = int'(va.x);
                        if (int'(va.x) > hs_max) hs_max = int'(va.x);
                    end
                    if (va.line_start) ls_cnt++;
                end else begin
                    chk("A.wrap.x", int'(va.x), 0);
                    chk("A.wrap.y", int'(va.y), 1);
                    chk("A.wrap.line_start", int'(va.line_start), 1);
                end
                samples++;
            end
        end
        chk("A.line.samples", samples, 801);
        chk("A.line.sequence_errors", seq_bad, 0);
        chk("A.line.video_on_count", von_cnt, 640);
        chk("A.line.video_on_outside", von_bad, 0);
        chk("A.line.hsync_count", hs_cnt, 96);
        chk("A.line.hsync_first", hs_min, 656);
        chk("A.line.hsync_last", hs_max, 751);
        chk("A.line.line_start_count", ls_cnt, 1);

        // Freeze at (100,5) for 10 clocks, then resume
        wait_a_xy(100, 5, 10000, "A.reach_100_5");
        #1; va.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_50MHz);
            chk("A.freeze.x", int'(va.x), 100);
            chk("A.freeze.y", int'(va.y), 5);
            chk("A.freeze.p_tick", int'(va.p_tick), 0);
            chk("A.freeze.video_on", int'(va.video_on), 1);
        end
        #1; va.enable = 1'b1;
        k = 0;
        while (int'(va.x) == 100 && k < 4) begin
            @(negedge clk_50MHz);
            k++;
        end
        chk("A.resume.x", int'(va.x), 101);

        // Restart inside the hsync pulse
        wait_a_xy(700, 5, 2000, "A.reach_700_5");
        chk("A.pre_restart.hsync", int'(va.hsync), 0);
        fc_hold = int'(va.frame_count);
        #1; va.restart = 1'b1;
        run(1);
        chk("A.restart.x", int'(va.x), 0);
        chk("A.restart.y", int'(va.y), 0);
        chk("A.restart.hsync", int'(va.hsync), 1);
        chk("A.restart.video_on", int'(va.video_on), 1);
        chk("A.restart.frame_count", int'(va.frame_count), fc_hold);
        #1; va.restart = 1'b0;

        // Random enable/restart/reset traffic; B runs long enough to wrap frame_count
        vb.enable = 1'b1;
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk_50MHz);
            #1;
            a_reset    = ($urandom_range(0, 1999) == 0);
            va.restart = ($urandom_range(0, 499) == 0);
            va.enable  = ($urandom_range(0, 9) != 0);
            vb.restart = ($urandom_range(0, 999) == 0);
            vb.enable  = ($urandom_range(0, 9) != 0);
        end
        @(negedge clk_50MHz);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
